// File: rtl/gate_op_if.sv
// Request/result bundle between requesters, the gate-op scheduler, and the result sink.
// The four requesters' operands are packed side by side: requester i occupies slice i.
interface gate_op_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req_valid;
    logic [3:0]         req_ready;
    logic [4*WIDTH-1:0] req_a;
    logic [4*WIDTH-1:0] req_b;
    logic [11:0]        req_op;
    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_data;
    logic [1:0]         res_id;
    logic               res_err;
    logic [15:0]        done_cnt;

    modport master (
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_err, done_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_data, res_id, res_err, done_cnt
    );
endinterface

// File: rtl/gate_op_scheduler.sv
// Round-robin arbiter over four requesters feeding a single registered bitwise-gate stage.
//   state | meaning
//   IDLE  | no result held, any granted request is accepted
//   HOLD  | result held on res_*, new request accepted only when the sink takes it
module gate_op_scheduler #(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    gate_op_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       id_q, id_d;
    logic             err_q, err_d;
    logic [15:0]      done_q, done_d;

    logic             gnt_found;
    logic [1:0]       gnt_idx;
    logic [1:0]       cand;
    logic             accept;
    logic [2:0]       op;
    logic [WIDTH-1:0] opa, opb, gate_res;
    logic             gate_err;

    // First valid requester searching upward from ptr, wrapping mod 4.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        opa      = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        opb      = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        op       = bus.req_op[int'(gnt_idx)*3 +: 3];
        gate_res = '0;
        gate_err = 1'b0;
        case (op)
            3'b000:  gate_res = opa & opb;
            3'b001:  gate_res = opa | opb;
            3'b010:  gate_res = ~opa;
            3'b011:  gate_res = ~(opa & opb);
            3'b100:  gate_res = ~(opa | opb);
            3'b101:  gate_res = opa ^ opb;
            3'b110:  gate_res = ~(opa ^ opb);
            default: gate_err = 1'b1;
        endcase
    end

    assign accept        = gnt_found && (state_q == IDLE || bus.res_ready) && !rst;
    assign bus.req_ready = accept ? (4'b0001 << gnt_idx) : 4'b0000;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;
        done_d  = done_q;
        if (state_q == HOLD && bus.res_ready) begin
            done_d  = done_q + 16'd1;
            state_d = IDLE;
        end
        // A fresh accept overrides the drain to IDLE, giving back-to-back results.
        if (accept) begin
            state_d = HOLD;
            ptr_d   = gnt_idx + 2'd1;
            data_d  = gate_res;
            id_d    = gnt_idx;
            err_d   = gate_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            data_q  <= '0;
            id_q    <= 2'd0;
            err_q   <= 1'b0;
            done_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign bus.res_valid = (state_q == HOLD);
    assign bus.res_data  = data_q;
    assign bus.res_id    = id_q;
    assign bus.res_err   = err_q;
    assign bus.done_cnt  = done_q;
endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed bench for gate_op_scheduler: reset, single op, gate sweep, backpressure,
// reset during HOLD, and round-robin fairness, with hand-computed expectations.
module tb_gate_op_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    gate_op_if #(.WIDTH(8)) bus ();

    gate_op_scheduler #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        checks   = 0;
        failures = 0;
        sweep_exp[0] = 8'h88; sweep_exp[1] = 8'hEE; sweep_exp[2] = 8'h55; sweep_exp[3] = 8'h77;
        sweep_exp[4] = 8'h11; sweep_exp[5] = 8'h66; sweep_exp[6] = 8'h99; sweep_exp[7] = 8'h00;

        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        // Reset state, and req_ready must stay low under reset even with requests pending.
        bus.req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
        chk("rst_res_data",  32'(bus.res_data),  32'h0);
        chk("rst_res_id",    32'(bus.res_id),    32'h0);
        chk("rst_res_err",   32'(bus.res_err),   32'h0);
        chk("rst_done_cnt",  32'(bus.done_cnt),  32'h0);
        bus.req_valid = 4'b0000;
        tick();
        rst = 1'b0;

        // Single request from requester 2; other slices carry junk that must be ignored.
        bus.req_a  = 32'h11F0_2233;
        bus.req_b  = 32'h443C_5566;
        bus.req_op = 12'b111_101_111_111;
        bus.req_valid = 4'b0100;
        #1;
        chk("single_req_ready", 32'(bus.req_ready), 32'h4);
        tick();
        chk("single_res_valid", 32'(bus.res_valid), 32'h1);
        chk("single_res_data",  32'(bus.res_data),  32'hCC);
        chk("single_res_id",    32'(bus.res_id),    32'h2);
        chk("single_res_err",   32'(bus.res_err),   32'h0);
        bus.req_valid = 4'b0000;
        bus.res_ready = 1'b1;
        tick();
        chk("single_drain_valid", 32'(bus.res_valid), 32'h0);
        chk("single_drain_cnt",   32'(bus.done_cnt),  32'h1);

        // Gate sweep back-to-back on requester 0 (ptr=3 wraps to 0), ending with illegal op.
        bus.req_a     = 32'h0000_00AA;
        bus.req_b     = 32'h0000_00CC;
        bus.req_valid = 4'b0001;
        for (int op = 0; op < 8; op++) begin
            bus.req_op = 12'(op);
            #1;
            chk($sformatf("sweep_ready_op%0d", op), 32'(bus.req_ready), 32'h1);
            tick();
            chk($sformatf("sweep_data_op%0d", op), 32'(bus.res_data), 32'(sweep_exp[op]));
            chk($sformatf("sweep_err_op%0d", op),  32'(bus.res_err),  (op == 7) ? 32'h1 : 32'h0);
        end
        chk("sweep_cnt_midstream", 32'(bus.done_cnt), 32'd8);
        bus.req_valid = 4'b0000;
        tick();
        chk("sweep_drain_valid", 32'(bus.res_valid), 32'h0);
        chk("sweep_drain_cnt",   32'(bus.done_cnt),  32'd9);

        // Backpressure: hold 0x0F|0xF0 for 3 cycles while requester 1 waits.
        bus.res_ready = 1'b0;
        bus.req_a     = 32'h0000_000F;
        bus.req_b     = 32'h0000_00F0;
        bus.req_op    = 12'b000_000_000_001;
        bus.req_valid = 4'b0001;
        #1;
        chk("bp_first_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_a     = 32'h0000_3C00;
        bus.req_b     = 32'h0000_0F00;
        bus.req_op    = 12'b000_000_000_000;
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_stall_ready_c%0d", c), 32'(bus.req_ready), 32'h0);
            chk($sformatf("bp_stall_data_c%0d", c),  32'(bus.res_data),  32'hFF);
            chk($sformatf("bp_stall_valid_c%0d", c), 32'(bus.res_valid), 32'h1);
            chk($sformatf("bp_stall_cnt_c%0d", c),   32'(bus.done_cnt),  32'd9);
            tick();
        end
        bus.res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.req_ready), 32'h2);
        tick();
        chk("bp_next_data", 32'(bus.res_data), 32'h0C);
        chk("bp_next_id",   32'(bus.res_id),   32'h1);
        chk("bp_next_cnt",  32'(bus.done_cnt), 32'd10);
        bus.req_valid = 4'b0000;
        tick();
        chk("bp_drain_cnt", 32'(bus.done_cnt), 32'd11);

        // Reset while holding a result: result discarded, pointer back to 0.
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b0100;
        tick();
        chk("rh_hold_valid", 32'(bus.res_valid), 32'h1);
        bus.req_valid = 4'b0000;
        rst = 1'b1;
        tick();
        chk("rh_res_valid", 32'(bus.res_valid), 32'h0);
        chk("rh_done_cnt",  32'(bus.done_cnt),  32'h0);
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        chk("rh_first_grant", 32'(bus.req_ready), 32'h1);

        // Fairness from reset: ids 0,1,2,3,0 on consecutive cycles.
        bus.res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr_ready_%0d", i), 32'(bus.req_ready), 32'(4'b0001 << (i % 4)));
            tick();
            chk($sformatf("rr_id_%0d", i), 32'(bus.res_id), 32'(i % 4));
        end
        bus.req_valid = 4'b0000;
        tick();
        chk("rr_done_cnt", 32'(bus.done_cnt),  32'd5);
        chk("rr_idle",     32'(bus.res_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
